// File: rtl/alu_issue.sv
// Issue buffer: decodes RV32 ALU ops into a 2-entry FIFO feeding the ALU stage.
// Optional saturating illegal-op counter when ALU_ISSUE_ILLEGAL_CNT_EN is defined.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic        is_imm,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_sayi1,
  output logic [31:0] alu_sayi2,
  output logic [2:0]  alu_select,
  output logic        err_illegal
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  ,
  output logic [15:0] illegal_cnt
`endif
);

  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  sel;
  } entry_t;

  entry_t     mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       alive;

  logic       dec_legal;
  logic [2:0] dec_sel;
  logic       xfer;
  logic       push;
  logic       pop;

  always_comb begin
    dec_legal = 1'b1;
    dec_sel   = 3'b000;
    case (funct3)
      3'b000:  dec_sel = (!is_imm && funct7b5) ? 3'b001 : 3'b000;
      3'b111:  dec_sel = 3'b010;
      3'b100:  dec_sel = 3'b011;
      3'b011:  dec_sel = 3'b101;
      default: dec_legal = 1'b0;
    endcase
  end

  // alive holds in_ready low until the first edge after reset releases
  assign in_ready  = alive && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign xfer      = in_valid && in_ready;
  assign push      = xfer && dec_legal;
  assign pop       = out_valid && out_ready;

  assign alu_sayi1  = out_valid ? mem[rd_ptr].op1 : 32'd0;
  assign alu_sayi2  = out_valid ? mem[rd_ptr].op2 : 32'd0;
  assign alu_select = out_valid ? mem[rd_ptr].sel : 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive       <= 1'b0;
      count       <= 2'd0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      err_illegal <= 1'b0;
      for (int i = 0; i < 2; i++) mem[i] <= '0;
    end else begin
      alive       <= 1'b1;
      err_illegal <= xfer && !dec_legal;
      if (push) begin
        mem[wr_ptr] <= '{op1: rs1_val, op2: (is_imm ? imm : rs2_val), sel: dec_sel};
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      count <= count + 2'd1;
      else if (pop && !push) count <= count - 2'd1;
    end
  end

`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      illegal_cnt <= 16'd0;
    else if (err_illegal && illegal_cnt != 16'hFFFF)
      illegal_cnt <= illegal_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Directed-vector bench for alu_issue with hand-computed expectations.
// Covers decode, backpressure, illegal drop, push/pop overlap and mid-flight reset.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic        is_imm;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_sayi1;
  logic [31:0] alu_sayi2;
  logic [2:0]  alu_select;
  logic        err_illegal;
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  alu_issue dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .imm        (imm),
    .is_imm     (is_imm),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .alu_sayi1  (alu_sayi1),
    .alu_sayi2  (alu_sayi2),
    .alu_select (alu_select),
    .err_illegal(err_illegal)
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    ,
    .illegal_cnt(illegal_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] f3, input logic f7, input logic im_sel,
                        input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] iv);
    funct3   = f3;
    funct7b5 = f7;
    is_imm   = im_sel;
    rs1_val  = r1;
    rs2_val  = r2;
    imm      = iv;
  endtask

  logic [2:0] f3_tab  [3];
  logic [2:0] sel_tab [3];

  initial begin
    f3_tab[0] = 3'b111; sel_tab[0] = 3'b010;
    f3_tab[1] = 3'b100; sel_tab[1] = 3'b011;
    f3_tab[2] = 3'b011; sel_tab[2] = 3'b101;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_op(3'b000, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_sayi1",     alu_sayi1,          32'd0);
    chk("rst_err",       {31'd0, err_illegal}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD
    set_op(3'b000, 1'b0, 1'b0, 32'd5, 32'd3, 32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("add_valid", {31'd0, out_valid}, 32'd1);
    chk("add_sayi1", alu_sayi1, 32'd5);
    chk("add_sayi2", alu_sayi2, 32'd3);
    chk("add_sel",   {29'd0, alu_select}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("empty_valid", {31'd0, out_valid}, 32'd0);
    chk("empty_sayi1", alu_sayi1, 32'd0);
    chk("empty_sayi2", alu_sayi2, 32'd0);

    // SUB
    set_op(3'b000, 1'b1, 1'b0, 32'd10, 32'd4, 32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("sub_sel",   {29'd0, alu_select}, 32'd1);
    chk("sub_sayi2", alu_sayi2, 32'd4);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // ADDI with funct7b5 set, which must be ignored
    set_op(3'b000, 1'b1, 1'b1, 32'd1, 32'd7, 32'hFFFF_FFFF);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("addi_sayi2", alu_sayi2, 32'hFFFF_FFFF);
    chk("addi_sel",   {29'd0, alu_select}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;

    // AND / XOR / SLTU
    for (int i = 0; i < 3; i++) begin
      set_op(f3_tab[i], 1'b0, 1'b0, 32'd20 + i, 32'd30 + i, 32'd0);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("logic_sel",   {29'd0, alu_select}, {29'd0, sel_tab[i]});
      chk("logic_sayi1", alu_sayi1, 32'd20 + i);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end

    // Backpressure: three ops, FIFO fills after two
    set_op(3'b000, 1'b0, 1'b0, 32'd1, 32'd0, 32'd0);
    in_valid = 1'b1;
    step();
    chk("bp_ready_1", {31'd0, in_ready}, 32'd1);
    rs1_val = 32'd2;
    step();
    chk("bp_ready_2", {31'd0, in_ready}, 32'd0);
    rs1_val = 32'd3;
    step();
    chk("bp_ready_held", {31'd0, in_ready}, 32'd0);
    chk("bp_head_1", alu_sayi1, 32'd1);
    out_ready = 1'b1;
    step();
    chk("bp_head_2",  alu_sayi1, 32'd2);
    chk("bp_ready_3", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_head_3",  alu_sayi1, 32'd3);
    chk("bp_valid_3", {31'd0, out_valid}, 32'd1);
    step();
    out_ready = 1'b0;
    chk("bp_drained", {31'd0, out_valid}, 32'd0);

    // Illegal op
    set_op(3'b001, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("ill_err",   {31'd0, err_illegal}, 32'd1);
    chk("ill_valid", {31'd0, out_valid},   32'd0);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    chk("ill_cnt_pre", {16'd0, illegal_cnt}, 32'd0);
`endif
    step();
    chk("ill_err_pulse", {31'd0, err_illegal}, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
    chk("ill_cnt", {16'd0, illegal_cnt}, 32'd1);
`endif

    // Simultaneous push and pop at count=1
    set_op(3'b000, 1'b0, 1'b0, 32'h11, 32'd0, 32'd0);
    in_valid = 1'b1;
    step();
    rs1_val   = 32'h22;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("pp_valid", {31'd0, out_valid}, 32'd1);
    chk("pp_head",  alu_sayi1, 32'h22);
    chk("pp_ready", {31'd0, in_ready}, 32'd1);

    // Fill to two, then reset between edges
    rs1_val  = 32'h33;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("full_ready", {31'd0, in_ready}, 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_sayi1", alu_sayi1, 32'd0);
    chk("mrst_sayi2", alu_sayi2, 32'd0);
    chk("mrst_sel",   {29'd0, alu_select}, 32'd0);
    chk("mrst_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();
    chk("mrst_ready_after", {31'd0, in_ready},  32'd1);
    chk("mrst_valid_after", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
